// File: rtl/ahb_slave_pipe.sv
// AHB slave front end of the AHB-to-APB bridge. It registers the address phase,
// decodes the APB slave select, pairs write data with its address, and drives the two-cycle ERROR response.
module ahb_slave_pipe #(
  parameter int WIDTH = 32,
  parameter int NSLV  = 3
) (
  input  logic             Hclk,
  input  logic             Hreset,
  input  logic [1:0]       Htrans,
  input  logic             Hwrite,
  input  logic [2:0]       Hsize,
  input  logic             Hreadyin,
  input  logic [WIDTH-1:0] Haddr,
  input  logic [WIDTH-1:0] Hwdata,
  input  logic             apb_ready,
  output logic             valid,
  output logic [WIDTH-1:0] haddr_q,
  output logic             hwrite_q,
  output logic [NSLV-1:0]  tempselx,
  output logic [WIDTH-1:0] haddr_d,
  output logic [WIDTH-1:0] hwdata_d,
  output logic             Hreadyout,
  output logic [1:0]       Hresp
);

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} st_e;

  st_e              st_q;
  logic             resp_err_q, rdy_low_q, rst_q;
  logic             acc, mapped, bad, good;
  logic [3:0]       rgn;
  logic [NSLV-1:0]  sel;

  logic             a_vld_q, a_vld_d, a_wr_q, a_wr_d;
  logic [WIDTH-1:0] a_addr_q, a_addr_d, d_addr_q, d_addr_d, d_wdata_q, d_wdata_d;
  logic [NSLV-1:0]  a_sel_q, a_sel_d;

  // Each slave owns a 64 MB window starting at 0x8000_0000.
  assign rgn    = Haddr[WIDTH-3 -: 4];
  assign mapped = (Haddr[WIDTH-1 -: 2] == 2'b10) && (rgn < 4'(NSLV));
  assign acc    = Hreadyin && Htrans[1];
  assign bad    = acc && (!mapped || (Hsize > 3'd2));
  assign good   = acc && !bad;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NSLV; i++) sel[i] = mapped && (rgn == 4'(i));
  end

  always_comb begin
    a_vld_d   = a_vld_q;
    a_wr_d    = a_wr_q;
    a_addr_d  = a_addr_q;
    a_sel_d   = a_sel_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    if (Hreadyin) begin
      if (a_vld_q && a_wr_q) begin
        d_addr_d  = a_addr_q;
        d_wdata_d = Hwdata;
      end
      a_vld_d = good;
      a_sel_d = good ? sel : '0;
      if (good) begin
        a_addr_d = Haddr;
        a_wr_d   = Hwrite;
      end
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      a_vld_q   <= 1'b0;
      a_wr_q    <= 1'b0;
      a_addr_q  <= '0;
      a_sel_q   <= '0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
    end else begin
      a_vld_q   <= a_vld_d;
      a_wr_q    <= a_wr_d;
      a_addr_q  <= a_addr_d;
      a_sel_q   <= a_sel_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
    end
  end

  // Error FSM; resp_err_q / rdy_low_q are the registered per-state response flags.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      st_q       <= ST_IDLE;
      resp_err_q <= 1'b0;
      rdy_low_q  <= 1'b0;
      rst_q      <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      case (st_q)
        ST_IDLE: if (bad) begin
          st_q <= ST_ERR1; resp_err_q <= 1'b1; rdy_low_q <= 1'b1;
        end
        ST_ERR1: begin
          st_q <= ST_ERR2; resp_err_q <= 1'b1; rdy_low_q <= 1'b0;
        end
        ST_ERR2: if (bad) begin
          st_q <= ST_ERR1; resp_err_q <= 1'b1; rdy_low_q <= 1'b1;
        end else begin
          st_q <= ST_IDLE; resp_err_q <= 1'b0; rdy_low_q <= 1'b0;
        end
        default: begin
          st_q <= ST_IDLE; resp_err_q <= 1'b0; rdy_low_q <= 1'b0;
        end
      endcase
    end
  end

  // Ready/OKAY is forced during reset and for the cycle right after it.
  logic force_ok;
  assign force_ok  = Hreset || rst_q;
  assign Hreadyout = force_ok || (!rdy_low_q && (resp_err_q || apb_ready));
  assign Hresp     = {1'b0, resp_err_q && !force_ok};

  assign valid    = a_vld_q;
  assign haddr_q  = a_addr_q;
  assign hwrite_q = a_wr_q;
  assign tempselx = a_sel_q;
  assign haddr_d  = d_addr_q;
  assign hwdata_d = d_wdata_q;

endmodule

// File: tb/tb_ahb_slave_pipe.sv
// Bench for ahb_slave_pipe: directed plan steps plus random traffic, checked against a transfer-level model.
module tb_ahb_slave_pipe;
  logic        Hclk = 1'b0, Hreset = 1'b1;
  logic [1:0]  Htrans = 2'b00;
  logic        Hwrite = 1'b0, apb_ready = 1'b1, ext_rdy = 1'b1;
  logic [2:0]  Hsize = 3'd2;
  logic        Hreadyin;
  logic [31:0] Haddr = '0, Hwdata = '0;
  logic        valid, hwrite_q, Hreadyout;
  logic [31:0] haddr_q, haddr_d, hwdata_d;
  logic [2:0]  tempselx;
  logic [1:0]  Hresp;

  int n_tests = 0, n_fail = 0;

  // Global HREADY is this slave's ready, optionally held low by another slave.
  assign Hreadyin = Hreadyout & ext_rdy;

  always #5 Hclk = ~Hclk;

  ahb_slave_pipe #(.WIDTH(32), .NSLV(3)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize),
    .Hreadyin(Hreadyin), .Haddr(Haddr), .Hwdata(Hwdata), .apb_ready(apb_ready),
    .valid(valid), .haddr_q(haddr_q), .hwrite_q(hwrite_q), .tempselx(tempselx),
    .haddr_d(haddr_d), .hwdata_d(hwdata_d), .Hreadyout(Hreadyout), .Hresp(Hresp));

  // Model: transfer in data phase, last write pair, and a count of remaining error cycles.
  bit          m_known = 0, m_rst = 0, m_valid = 0, m_write = 0;
  logic [31:0] m_addr = '0, m_daddr = '0, m_wdata = '0;
  logic [2:0]  m_sel = '0;
  int          m_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_map(input logic [31:0] a);
    return a >= 32'h8000_0000 && a < 32'h8C00_0000;
  endfunction

  task automatic cyc(input logic [1:0] tr, input logic [31:0] a, input logic w,
                     input logic [2:0] sz, input logic [31:0] wd, input logic ar,
                     input logic rst, input logic er);
    bit acc, bad, good;
    @(negedge Hclk);
    if (m_known) begin
      chk("valid", 32'(valid), 32'(m_valid));
      chk("tempselx", 32'(tempselx), 32'(m_sel));
      if (m_valid) begin
        chk("haddr_q", haddr_q, m_addr);
        chk("hwrite_q", 32'(hwrite_q), 32'(m_write));
      end
      chk("haddr_d", haddr_d, m_daddr);
      chk("hwdata_d", hwdata_d, m_wdata);
    end
    Htrans = tr; Haddr = a; Hwrite = w; Hsize = sz; Hwdata = wd;
    apb_ready = ar; Hreset = rst; ext_rdy = er;
    #1;
    if (m_known || rst) begin
      if (rst || m_rst) begin
        chk("rdy_rst", 32'(Hreadyout), 32'd1);
        chk("resp_rst", 32'(Hresp), 32'd0);
      end else begin
        chk("hreadyout", 32'(Hreadyout), (m_err == 2) ? 32'd0 : (m_err == 1) ? 32'd1 : 32'(ar));
        chk("hresp", 32'(Hresp), (m_err > 0) ? 32'd1 : 32'd0);
      end
    end
    if (rst) begin
      m_known = 1; m_rst = 1; m_valid = 0; m_write = 0; m_sel = '0;
      m_addr = '0; m_daddr = '0; m_wdata = '0; m_err = 0;
    end else if (m_known) begin
      acc  = Hreadyin && tr[1];
      bad  = acc && (!in_map(a) || sz > 3'd2);
      good = acc && !bad;
      m_rst = 0;
      if (m_err == 2) m_err = 1;
      else if (bad) m_err = 2;
      else m_err = 0;
      if (Hreadyin) begin
        if (m_valid && m_write) begin m_daddr = m_addr; m_wdata = wd; end
        m_valid = good;
        m_sel = good ? 3'(1 << ((a - 32'h8000_0000) / 32'h0400_0000)) : 3'd0;
        if (good) begin m_addr = a; m_write = w; end
      end
    end
    @(posedge Hclk);
  endtask

  initial begin
    logic [31:0] a, r;
    // Reset held two cycles with NONSEQ on the bus
    cyc(2'b10, 32'h8000_0000, 1'b1, 3'd2, '0, 1'b1, 1'b1, 1'b1);
    cyc(2'b10, 32'h8000_0000, 1'b1, 3'd2, '0, 1'b1, 1'b1, 1'b1);
    #1; chk("rst_valid", 32'(valid), 32'd0); chk("rst_sel", 32'(tempselx), 32'd0);
    // Single write
    cyc(2'b10, 32'h8000_0010, 1'b1, 3'd2, '0, 1'b1, 1'b0, 1'b1);
    #1; chk("wr_valid", 32'(valid), 32'd1); chk("wr_sel", 32'(tempselx), 32'd1);
    chk("wr_addr", haddr_q, 32'h8000_0010);
    cyc(2'b00, '0, 1'b0, 3'd2, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    #1; chk("wr_data", hwdata_d, 32'hDEAD_BEEF); chk("wr_daddr", haddr_d, 32'h8000_0010);
    // Unmapped address, then oversize transfer
    cyc(2'b10, 32'h9000_0000, 1'b0, 3'd2, '0, 1'b1, 1'b0, 1'b1);
    #1; chk("um_resp1", 32'(Hresp), 32'd1); chk("um_rdy1", 32'(Hreadyout), 32'd0);
    chk("um_valid", 32'(valid), 32'd0);
    cyc(2'b00, '0, 1'b0, 3'd2, '0, 1'b1, 1'b0, 1'b1);
    #1; chk("um_resp2", 32'(Hresp), 32'd1); chk("um_rdy2", 32'(Hreadyout), 32'd1);
    cyc(2'b00, '0, 1'b0, 3'd2, '0, 1'b1, 1'b0, 1'b1);
    #1; chk("um_resp3", 32'(Hresp), 32'd0);
    cyc(2'b10, 32'h8000_0000, 1'b1, 3'd3, '0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, '0, 1'b0, 3'd2, '0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, '0, 1'b0, 3'd2, '0, 1'b1, 1'b0, 1'b1);
    // Read burst to slave 1
    cyc(2'b10, 32'h8400_0000, 1'b0, 3'd2, '0, 1'b1, 1'b0, 1'b1);
    cyc(2'b11, 32'h8400_0004, 1'b0, 3'd2, '0, 1'b1, 1'b0, 1'b1);
    #1; chk("bu_addr1", haddr_q, 32'h8400_0004); chk("bu_sel", 32'(tempselx), 32'd2);
    cyc(2'b11, 32'h8400_0008, 1'b0, 3'd2, '0, 1'b1, 1'b0, 1'b1);
    #1; chk("bu_valid", 32'(valid), 32'd1); chk("bu_data", hwdata_d, 32'hDEAD_BEEF);
    cyc(2'b00, '0, 1'b0, 3'd2, '0, 1'b1, 1'b0, 1'b1);
    // Write stalled by the APB side for 3 cycles
    cyc(2'b10, 32'h8800_0020, 1'b1, 3'd1, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(2'b00, '0, 1'b0, 3'd2, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    #1; chk("st_hold", hwdata_d, 32'hDEAD_BEEF); chk("st_valid", 32'(valid), 32'd1);
    cyc(2'b00, '0, 1'b0, 3'd2, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1);
    #1; chk("st_done", hwdata_d, 32'hCAFE_F00D); chk("st_daddr", haddr_d, 32'h8800_0020);
    // Reset during ERR1
    cyc(2'b10, 32'h8C00_0000, 1'b0, 3'd2, '0, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, '0, 1'b0, 3'd2, '0, 1'b1, 1'b1, 1'b1);
    cyc(2'b01, 32'h8000_0000, 1'b0, 3'd2, '0, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, 32'h8000_0000, 1'b0, 3'd2, '0, 1'b1, 1'b0, 1'b1);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000 + {6'd0, r[25:2], 2'b00};
        1: a = 32'h8400_0000 + {6'd0, r[25:2], 2'b00};
        2: a = 32'h8800_0000 + {6'd0, r[25:2], 2'b00};
        3: a = 32'h83FF_FFFC;
        4: a = 32'h8BFF_FFFC;
        5: a = 32'h8C00_0000;
        6: a = 32'h7FFF_FFFC;
        default: a = r;
      endcase
      cyc(2'($urandom_range(0, 3)), a, 1'($urandom), ($urandom_range(0, 5) == 0) ? 3'd3 : 3'($urandom_range(0, 2)),
          $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0));
    end
    cyc(2'b00, '0, 1'b0, 3'd2, '0, 1'b1, 1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_slave_pipe.md
Name: ahb_slave_pipe

Overview:
- AHB slave-side front end of the AHB-to-APB bridge; consumes the master-driven AHB bus signals (Htrans, Hwrite, Hsize, Hreadyin, Haddr, Hwdata) and produces Hreadyout/Hresp.
- Registers address/control, decodes the APB slave select, and aligns write data with its address for the downstream APB controller FSM.
- Generates the two-cycle AHB ERROR response for unmapped or unsupported transfers.

Parameters:
- WIDTH, 32, address/data width (Haddr, Hwdata, internal registers).
- NSLV, 3, number of APB slave selects (tempselx width).

Ports:
- Hclk  input  1  bridge clock; all state updates on posedge.
- Hreset  input  1  synchronous, active-high reset.
- Htrans  input  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- Hwrite  input  1  1 = write, 0 = read.
- Hsize  input  3  transfer size.
- Hreadyin  input  1  global HREADY; pipeline advances only when 1.
- Haddr  input  WIDTH  AHB address.
- Hwdata  input  WIDTH  AHB write data, driven in the data phase.
- apb_ready  input  1  APB controller can accept the current data phase.
- valid  output  1  registered; a mapped transfer is in its data phase.
- haddr_q  output  WIDTH  address of the transfer in its data phase.
- hwrite_q  output  1  direction of the transfer in its data phase.
- tempselx  output  NSLV  one-hot slave select of the transfer in its data phase.
- haddr_d  output  WIDTH  address paired with hwdata_d (one stage later).
- hwdata_d  output  WIDTH  captured write data.
- Hreadyout  output  1  slave ready to AHB.
- Hresp  output  2  00 OKAY, 01 ERROR.

Behaviour:
- Reset (Hreset=1 at posedge):
  - valid, hwrite_q, tempselx, haddr_q, haddr_d, hwdata_d go to 0.
  - Error FSM goes to IDLE.
  - Hresp=00 and Hreadyout=1 while Hreset=1 and on the following cycle.
  - Reset wins over all other events, including mid-error.
- Accept condition (acc): Hreadyin=1 and Htrans[1]=1 (NONSEQ or SEQ).
  - IDLE and BUSY are never accepted.
- Decode, combinational on Haddr. Any address outside these ranges is unmapped:
  - 0x8000_0000–0x83FF_FFFF -> sel 001.
  - 0x8400_0000–0x87FF_FFFF -> sel 010.
  - 0x8800_0000–0x8BFF_FFFF -> sel 100.
- Bad transfer: acc with an unmapped address, or with Hsize>2.
- Address stage (updates only when Hreadyin=1):
  - valid <= acc and not bad.
  - haddr_q <= Haddr, hwrite_q <= Hwrite, tempselx <= sel when acc and not bad.
  - tempselx <= 0 otherwise.
  - When Hreadyin=0, all address-stage registers hold.
- Data stage: on a posedge with valid=1, hwrite_q=1 and Hreadyin=1:
  - hwdata_d <= Hwdata and haddr_d <= haddr_q (latency: data registered 2 edges after the address phase).
  - Reads do not update haddr_d/hwdata_d.
- Error FSM:
  - IDLE -> ERR1 on a bad transfer.
  - ERR1 -> ERR2 unconditionally.
  - ERR2 -> IDLE, or ERR1 if another bad transfer is accepted in ERR2.
  - ERR1: Hresp=01, Hreadyout=0.
  - ERR2: Hresp=01, Hreadyout=1.
  - IDLE: Hresp=00, Hreadyout=apb_ready.
- A bad transfer never asserts valid.
- A good transfer accepted in ERR2 is processed normally (valid=1 next cycle).
- Back-to-back SEQ transfers with Hreadyin=1 keep valid high continuously; tempselx may change slave per beat.
- Stall: apb_ready=0 drives Hreadyout=0 (outside ERR1/ERR2), so the address and data stages hold.

Test Plan:
- Reset: hold Hreset=1 for 2 cycles with Htrans=10 -> valid=0, tempselx=000, Hresp=00, Hreadyout=1 throughout.
- Single write: NONSEQ, Haddr=0x8000_0010, Hwrite=1, Hsize=2, then Hwdata=0xDEADBEEF, apb_ready=1:
  - edge 1: valid=1, tempselx=001, haddr_q=0x8000_0010.
  - edge 2: hwdata_d=0xDEADBEEF, haddr_d=0x8000_0010.
- Unmapped: NONSEQ Haddr=0x9000_0000 -> cycle+1 Hresp=01/Hreadyout=0, cycle+2 Hresp=01/Hreadyout=1, cycle+3 Hresp=00; valid stays 0. Repeat with Haddr=0x8000_0000 and Hsize=3 -> same response.
- Burst: NONSEQ 0x8400_0000 then SEQ 0x8400_0004 and 0x8400_0008 (reads) -> valid=1 for 3 consecutive cycles, tempselx=010, haddr_q steps 0, 4, 8; hwdata_d unchanged.
- Stall: apb_ready=0 for 3 cycles during a write data phase -> Hreadyout=0; valid, haddr_q and hwdata_d hold; completes 1 edge after apb_ready=1.
- Reset in ERR1: assert Hreset during ERR1 -> next cycle Hresp=00, Hreadyout=1, FSM IDLE; BUSY/IDLE Htrans afterwards -> valid=0.
